// File: rtl/sr_ctrl_pkg.sv
// Shared types and constants for the SR latch pulse scheduler.
//   state_e  : scheduler FSM states
//   OP_SET   : operation code that pulses S (latch becomes 1)
//   OP_RESET : operation code that pulses R (latch becomes 0)
//   CntW     : width of the pulse/gap cycle counter
package sr_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StPulse,
    StGap
  } state_e;

  localparam logic OP_SET   = 1'b1;
  localparam logic OP_RESET = 1'b0;

  // Wide enough for the largest legal PULSE_W or GAP_W (15).
  localparam int unsigned CntW = 4;

endpackage

// File: rtl/sr_pulse_sched_if.sv
// Requester handshake and SR latch drive/feedback bundle.
//   req_a/op_a/ack_a : requester A command level, operation, accept strobe
//   req_b/op_b/ack_b : requester B, same meaning
//   q_fb             : latch Q feedback
//   s_out/r_out      : latch S and R drive
//   busy, q_exp, err : status (non-idle, expected Q, sticky mismatch)
// master = requesters plus latch side, slave = the scheduler.
interface sr_pulse_sched_if;
  logic req_a;
  logic op_a;
  logic ack_a;
  logic req_b;
  logic op_b;
  logic ack_b;
  logic q_fb;
  logic s_out;
  logic r_out;
  logic busy;
  logic q_exp;
  logic err;

  modport master (
    output req_a, op_a, req_b, op_b, q_fb,
    input  ack_a, ack_b, s_out, r_out, busy, q_exp, err
  );

  modport slave (
    input  req_a, op_a, req_b, op_b, q_fb,
    output ack_a, ack_b, s_out, r_out, busy, q_exp, err
  );
endinterface

// File: rtl/sr_rr_arbiter.sv
// Two-way round-robin arbiter.
//   clk, rst_n : clock, asynchronous active-low reset
//   req_i[1:0] : request bit 0 = A, bit 1 = B
//   accept_i   : the caller takes the current grant this cycle
//   gnt_o[1:0] : one-hot grant (combinational)
// A sole requester always wins; on a tie the one not granted last wins.
module sr_rr_arbiter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       accept_i,
  output logic [1:0] gnt_o
);

  // 1 = B granted last; reset value lets A win the first tie.
  logic last_b_q;

  always_comb begin
    gnt_o = req_i;
    if (req_i == 2'b11) begin
      gnt_o = last_b_q ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_b_q <= 1'b1;
    end else if (accept_i && (|req_i)) begin
      last_b_q <= gnt_o[1];
    end
  end

endmodule

// File: rtl/sr_pulse_sched.sv
// SR latch pulse scheduler: arbitrates set/reset commands from two requesters,
// drives S or R for PULSE_W cycles, holds both low for GAP_W cycles, tracks
// the expected latch state and flags feedback mismatches.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of sr_pulse_sched_if (handshakes, drive, status)
// Parameters: PULSE_W, GAP_W in 1..15.
module sr_pulse_sched
  import sr_ctrl_pkg::*;
#(
  parameter int unsigned PULSE_W = 3,
  parameter int unsigned GAP_W   = 2
) (
  input logic               clk,
  input logic               rst_n,
  sr_pulse_sched_if.slave   bus
);

  localparam logic [CntW-1:0] PulseLd = CntW'(PULSE_W - 1);
  localparam logic [CntW-1:0] GapLd   = CntW'(GAP_W - 1);

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic            op_q;
  logic            ack_a_q, ack_b_q;
  logic            s_q, r_q;
  logic            busy_q;
  logic            q_exp_q;
  logic            fb_valid_q;
  logic            err_q;

  logic [1:0] req;
  logic [1:0] gnt;
  logic       op_sel;
  logic       idle;

  assign req    = {bus.req_b, bus.req_a};
  assign idle   = (state_q == StIdle);
  assign op_sel = gnt[1] ? bus.op_b : bus.op_a;

  sr_rr_arbiter u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_i    (req),
    .accept_i (idle),
    .gnt_o    (gnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      op_q       <= OP_RESET;
      ack_a_q    <= 1'b0;
      ack_b_q    <= 1'b0;
      s_q        <= 1'b0;
      r_q        <= 1'b0;
      busy_q     <= 1'b0;
      q_exp_q    <= 1'b0;
      fb_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      ack_a_q <= 1'b0;
      ack_b_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (|req) begin
            state_q <= StPulse;
            cnt_q   <= PulseLd;
            op_q    <= op_sel;
            ack_a_q <= gnt[0];
            ack_b_q <= gnt[1];
            // S and R are decoded from one op bit, so they cannot overlap.
            s_q     <= (op_sel == OP_SET);
            r_q     <= (op_sel == OP_RESET);
            busy_q  <= 1'b1;
          end
        end
        StPulse: begin
          if (cnt_q == '0) begin
            state_q    <= StGap;
            cnt_q      <= GapLd;
            s_q        <= 1'b0;
            r_q        <= 1'b0;
            q_exp_q    <= op_q;
            fb_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StGap: begin
          if (cnt_q == '0) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            if (fb_valid_q && (bus.q_fb != q_exp_q)) begin
              err_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          s_q     <= 1'b0;
          r_q     <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ack_a = ack_a_q;
  assign bus.ack_b = ack_b_q;
  assign bus.s_out = s_q;
  assign bus.r_out = r_q;
  assign bus.busy  = busy_q;
  assign bus.q_exp = q_exp_q;
  assign bus.err   = err_q;

endmodule

// File: tb/tb_sr_pulse_sched.sv
module tb_sr_pulse_sched;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic force_fb = 1'b0;
  logic latch = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   overlap = 0;

  sr_pulse_sched_if bus ();

  sr_pulse_sched #(
    .PULSE_W (3),
    .GAP_W   (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Behavioural SR latch fed by the DUT drive; q_fb can be forced low.
  always @(posedge clk) begin
    if (bus.s_out) latch <= 1'b1;
    else if (bus.r_out) latch <= 1'b0;
  end
  assign bus.q_fb = force_fb ? 1'b0 : latch;

  always @(negedge clk) begin
    if (bus.s_out && bus.r_out) overlap++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic       ra;
    logic       oa;
    logic       rb;
    logic       ob;
    logic [6:0] exp;  // {ack_a, ack_b, s_out, r_out, busy, q_exp, err}
  } vec_t;

  vec_t vecs [24];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] outs();
    return {bus.ack_a, bus.ack_b, bus.s_out, bus.r_out, bus.busy, bus.q_exp, bus.err};
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 20; k++) begin
      if (!bus.busy) break;
      step();
    end
    chk("idle_timeout", {31'd0, bus.busy}, 32'd0);
  endtask

  task automatic do_cmd(input logic sel_b, input logic op);
    int k;
    if (sel_b) begin bus.req_b = 1'b1; bus.op_b = op; end
    else       begin bus.req_a = 1'b1; bus.op_a = op; end
    for (k = 0; k < 20; k++) begin
      step();
      if (sel_b ? bus.ack_b : bus.ack_a) break;
    end
    chk("cmd_ack", {31'd0, (sel_b ? bus.ack_b : bus.ack_a)}, 32'd1);
    bus.req_a = 1'b0;
    bus.req_b = 1'b0;
    wait_idle();
  endtask

  initial begin
    int  n;
    int  t [4];
    logic who [4];

    bus.req_a = 1'b0; bus.op_a = 1'b0;
    bus.req_b = 1'b0; bus.op_b = 1'b0;

    // Single A set, B reset with op change mid-pulse, redundant A reset on a
    // tie (A wins after B), then B pending across GAP.
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 7'b1010100};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 7'b0010100};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 7'b0010100};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 7'b0000110};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 7'b0000110};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 7'b0000010};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 7'b0101110};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 7'b0001110};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 7'b0001110};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 7'b0000100};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 7'b0000100};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 7'b0000000};
    vecs[12] = '{1'b1, 1'b0, 1'b1, 1'b1, 7'b1001100};
    vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b1, 7'b0001100};
    vecs[14] = '{1'b0, 1'b0, 1'b1, 1'b1, 7'b0001100};
    vecs[15] = '{1'b0, 1'b0, 1'b1, 1'b1, 7'b0000100};
    vecs[16] = '{1'b0, 1'b0, 1'b1, 1'b1, 7'b0000100};
    vecs[17] = '{1'b0, 1'b0, 1'b1, 1'b1, 7'b0000000};
    vecs[18] = '{1'b0, 1'b0, 1'b1, 1'b1, 7'b0110100};
    vecs[19] = '{1'b0, 1'b0, 1'b0, 1'b1, 7'b0010100};
    vecs[20] = '{1'b0, 1'b0, 1'b0, 1'b1, 7'b0010100};
    vecs[21] = '{1'b0, 1'b0, 1'b0, 1'b1, 7'b0000110};
    vecs[22] = '{1'b0, 1'b0, 1'b0, 1'b1, 7'b0000110};
    vecs[23] = '{1'b0, 1'b0, 1'b0, 1'b1, 7'b0000010};

    step();
    step();
    chk("reset_state", {25'd0, outs()}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 24; i++) begin
      bus.req_a = vecs[i].ra;
      bus.op_a  = vecs[i].oa;
      bus.req_b = vecs[i].rb;
      bus.op_b  = vecs[i].ob;
      step();
      chk($sformatf("vec%0d", i), {25'd0, outs()}, {25'd0, vecs[i].exp});
    end
    bus.req_a = 1'b0;
    bus.req_b = 1'b0;
    wait_idle();

    // Both requesters held: A first after reset, then strict alternation.
    do_reset();
    bus.req_a = 1'b1; bus.op_a = 1'b1;
    bus.req_b = 1'b1; bus.op_b = 1'b0;
    n = 0;
    for (int c = 0; c < 60 && n < 4; c++) begin
      step();
      if (bus.ack_a || bus.ack_b) begin
        t[n]   = c;
        who[n] = bus.ack_b;
        chk("grant_drive", {30'd0, bus.s_out, bus.r_out}, bus.ack_b ? 32'd1 : 32'd2);
        n++;
      end
    end
    chk("grant_count", n, 32'd4);
    for (int i = 0; i < n; i++) chk($sformatf("grant_order%0d", i), {31'd0, who[i]}, i % 2);
    for (int i = 1; i < n; i++) chk($sformatf("grant_gap%0d", i), t[i] - t[i-1], 32'd6);
    bus.req_a = 1'b0;
    bus.req_b = 1'b0;
    wait_idle();

    // Feedback mismatch: sticky err until reset.
    do_reset();
    force_fb = 1'b1;
    do_cmd(1'b0, 1'b1);
    chk("err_set", {31'd0, bus.err}, 32'd1);
    force_fb = 1'b0;
    do_cmd(1'b0, 1'b1);
    do_cmd(1'b1, 1'b0);
    chk("err_sticky", {31'd0, bus.err}, 32'd1);
    chk("q_exp_after_reset_cmd", {31'd0, bus.q_exp}, 32'd0);
    do_reset();
    chk("err_cleared", {31'd0, bus.err}, 32'd0);

    // Reset in the 2nd PULSE cycle of a set command aborts it.
    step();
    bus.req_a = 1'b1; bus.op_a = 1'b1;
    step();
    chk("abort_ack", {31'd0, bus.ack_a}, 32'd1);
    bus.req_a = 1'b0;
    step();
    chk("abort_pulse2", {31'd0, bus.s_out}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_outs", {25'd0, outs()}, 32'd0);
    #2;
    rst_n = 1'b1;
    step();
    step();
    chk("abort_idle", {25'd0, outs()}, 32'd0);
    do_cmd(1'b0, 1'b1);
    chk("abort_next_qexp", {31'd0, bus.q_exp}, 32'd1);
    chk("abort_next_err", {31'd0, bus.err}, 32'd0);

    chk("sr_overlap", overlap, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
